// File: rtl/seq_player.sv
// -----------------------------------------------------------------------------
// seq_player
//
// Playback stage for the FPGA side of the memory game. A 2^SIZE x 2-bit
// memory holds a pseudo-random colour sequence, filled from a free-running
// 8-bit LFSR on NEW_GAME. On START the sequence is shown on four one-hot
// LEDs, one element per step, while an external index counter is advanced
// through E_FPGA and its index/terminal-count flag are read back.
//
// Parameters
//   SIZE      index width; memory depth is 2^SIZE
//   ON_TICKS  cycles an element is lit (>= 1)
//   OFF_TICKS cycles dark between elements (>= 1)
//   SEED      LFSR reset value (non-zero)
//
// Ports
//   CLKHZ     in   clock, rising edge
//   R         in   synchronous active-high reset
//   START     in   pulse, begins playback (IDLE only)
//   NEW_GAME  in   pulse, regenerates the sequence memory (IDLE only, wins over START)
//   SEQFPGA   in   current sequence index from the external counter
//   end_FPGA  in   terminal-count flag from the external counter
//   ABORT     in   (only with SEQ_PLAYER_ABORT_EN) return to IDLE from any busy state
//   E_FPGA    out  one-cycle enable pulse to the counter, one per element
//   LEDS      out  one-hot colour display
//   COLOR     out  colour of the element currently shown
//   BUSY      out  high in every state except IDLE
//   DONE      out  one-cycle pulse when playback ends
//
// Optional feature macro: SEQ_PLAYER_ABORT_EN
// All outputs are registered; they are loaded from the next-state decode.
// -----------------------------------------------------------------------------
module seq_player #(
    parameter int         SIZE      = 4,
    parameter int         ON_TICKS  = 2,
    parameter int         OFF_TICKS = 1,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic            CLKHZ,
    input  logic            R,
    input  logic            START,
    input  logic            NEW_GAME,
    input  logic [SIZE-1:0] SEQFPGA,
    input  logic            end_FPGA,
`ifdef SEQ_PLAYER_ABORT_EN
    input  logic            ABORT,
`endif
    output logic            E_FPGA,
    output logic [3:0]      LEDS,
    output logic [1:0]      COLOR,
    output logic            BUSY,
    output logic            DONE
);

    localparam int DEPTH    = 2 ** SIZE;
    localparam int MAX_T    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW       = $clog2(MAX_T) + 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SHOW  = 3'd2,
        GAP   = 3'd3,
        STEP  = 3'd4,
        CHECK = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tick;
    logic [SIZE-1:0] fill_idx;
    logic [7:0]      lfsr;
    logic [1:0]      mem [DEPTH];

    logic            e_nxt;
    logic [3:0]      leds_nxt;
    logic [1:0]      color_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    // LFSR: Fibonacci, x^8 + x^6 + x^5 + x^4 + 1, free-running in every state
    always_ff @(posedge CLKHZ) begin
        if (R) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Sequence memory. Reset only clears it once the controller is already
    // idle: a held reset (power-up) zeroes every entry, while a short reset
    // during fill or playback leaves the contents untouched.
    always_ff @(posedge CLKHZ) begin
        if (R) begin
            if (state == IDLE) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= 2'b00;
                end
            end
        end else if (state == FILL) begin
            mem[fill_idx] <= lfsr[1:0];
        end
    end

    // State register
    always_ff @(posedge CLKHZ) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (NEW_GAME) begin
                    state_nxt = FILL;
                end else if (START) begin
                    state_nxt = SHOW;
                end
            end
            FILL:  if (fill_idx == {SIZE{1'b1}}) state_nxt = IDLE;
            SHOW:  if (tick == ON_LAST)          state_nxt = GAP;
            GAP:   if (tick == OFF_LAST)         state_nxt = STEP;
            STEP:  state_nxt = CHECK;
            CHECK: state_nxt = end_FPGA ? FIN : SHOW;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef SEQ_PLAYER_ABORT_EN
        if (ABORT && (state != IDLE)) begin
            state_nxt = IDLE;
        end
`endif
    end

    // Tick counter restarts on every state change; fill index runs only in FILL
    always_ff @(posedge CLKHZ) begin
        if (R) begin
            tick     <= '0;
            fill_idx <= '0;
        end else begin
            if (state_nxt != state) begin
                tick <= '0;
            end else begin
                tick <= tick + TW'(1);
            end
            if (state == FILL) begin
                fill_idx <= fill_idx + SIZE'(1);
            end else begin
                fill_idx <= '0;
            end
        end
    end

    // Output decode from the state being entered, so outputs line up with it
    always_comb begin
        color_nxt = COLOR;
        if ((state_nxt == SHOW) && (state != SHOW)) begin
            color_nxt = mem[SEQFPGA];
        end
        leds_nxt = (state_nxt == SHOW) ? (4'b0001 << color_nxt) : 4'b0000;
        e_nxt    = (state_nxt == STEP);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    always_ff @(posedge CLKHZ) begin
        if (R) begin
            E_FPGA <= 1'b0;
            LEDS   <= 4'b0000;
            COLOR  <= 2'b00;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            E_FPGA <= e_nxt;
            LEDS   <= leds_nxt;
            COLOR  <= color_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
        end
    end

endmodule
